peak_detector: RTL and testbench

Downstream stage of the shaping filters. Consumes the signed filter output stream, detects pulses crossing a programmable threshold, and reports one peak amplitude plus timestamp per pulse. Enforces a programmable dead time and flags over-long pulses as pile-up. Sits between a `vN_filter` instance and the readout/histogramming logic in the `filter` top level.

---
 rtl/peak_detector.sv | 156 +++++++++++++++
 tb/tb_peak_detector.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/peak_detector.sv
// Pulse peak detector: threshold trigger, strict-max tracking with timestamp, pile-up flag,
// programmable dead time and saturating event/reject counters.
module peak_detector #(
  parameter int DATA_WIDTH = 16,
  parameter int TIME_WIDTH = 32,
  parameter int MAX_WIDTH  = 255,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] input_data,
  input  logic signed [DATA_WIDTH-1:0] threshold,
  input  logic        [7:0]            dead_time,
  output logic                         peak_valid,
  output logic signed [DATA_WIDTH-1:0] peak_amplitude,
  output logic        [TIME_WIDTH-1:0] peak_time,
  output logic                         pile_up,
  output logic                         busy,
  output logic        [CNT_WIDTH-1:0]  event_count,
  output logic        [CNT_WIDTH-1:0]  reject_count
);

  localparam int WCW = $clog2(MAX_WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StArmed, StHoldoff} state_e;

  state_e                         state_q, state_d;
  logic signed [DATA_WIDTH-1:0]   sample_q;
  logic        [TIME_WIDTH-1:0]   sample_ts_q;
  logic        [TIME_WIDTH-1:0]   ts_q;
  logic                           above_prev_q;
  logic signed [DATA_WIDTH-1:0]   max_q, max_d;
  logic        [TIME_WIDTH-1:0]   max_ts_q, max_ts_d;
  logic        [WCW-1:0]          width_q, width_d;
  logic        [7:0]              dt_q, dt_d;
  logic                           emit_q, emit_d;
  logic                           emit_pile_q, emit_pile_d;
  logic                           reject_inc;
  logic                           above;

  logic                           peak_valid_q;
  logic signed [DATA_WIDTH-1:0]   peak_amp_q;
  logic        [TIME_WIDTH-1:0]   peak_time_q;
  logic                           pile_up_q;
  logic        [CNT_WIDTH-1:0]    event_q;
  logic        [CNT_WIDTH-1:0]    reject_q;

  assign above = sample_q > threshold;

  always_comb begin
    state_d     = state_q;
    max_d       = max_q;
    max_ts_d    = max_ts_q;
    width_d     = width_q;
    dt_d        = dt_q;
    emit_d      = 1'b0;
    emit_pile_d = 1'b0;
    reject_inc  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (above) begin
          state_d  = StArmed;
          max_d    = sample_q;
          max_ts_d = sample_ts_q;
          width_d  = WCW'(1);
        end
      end
      StArmed: begin
        if (!above || (width_q == WCW'(MAX_WIDTH))) begin
          // Exit sample is never compared into the running maximum.
          emit_d      = 1'b1;
          emit_pile_d = above;
          dt_d        = dead_time;
          state_d     = (dead_time == 8'd0) ? StIdle : StHoldoff;
        end else begin
          width_d = width_q + 1'b1;
          if (sample_q > max_q) begin
            max_d    = sample_q;
            max_ts_d = sample_ts_q;
          end
        end
      end
      StHoldoff: begin
        reject_inc = above && !above_prev_q;
        if (dt_q <= 8'd1) begin
          state_d = StIdle;
        end else begin
          dt_d = dt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      sample_q     <= '0;
      sample_ts_q  <= '0;
      ts_q         <= '0;
      above_prev_q <= 1'b0;
      max_q        <= '0;
      max_ts_q     <= '0;
      width_q      <= '0;
      dt_q         <= '0;
      emit_q       <= 1'b0;
      emit_pile_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_q     <= input_data;
      sample_ts_q  <= ts_q;
      ts_q         <= ts_q + 1'b1;
      above_prev_q <= above;
      max_q        <= max_d;
      max_ts_q     <= max_ts_d;
      width_q      <= width_d;
      dt_q         <= dt_d;
      emit_q       <= emit_d;
      emit_pile_q  <= emit_pile_d;
    end
  end

  // Report stage: outputs hold between emits, only peak_valid strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_valid_q <= 1'b0;
      peak_amp_q   <= '0;
      peak_time_q  <= '0;
      pile_up_q    <= 1'b0;
      event_q      <= '0;
      reject_q     <= '0;
    end else begin
      peak_valid_q <= emit_q;
      if (emit_q) begin
        peak_amp_q  <= max_q;
        peak_time_q <= max_ts_q;
        pile_up_q   <= emit_pile_q;
        if (event_q != '1) begin
          event_q <= event_q + 1'b1;
        end
      end
      if (reject_inc && (reject_q != '1)) begin
        reject_q <= reject_q + 1'b1;
      end
    end
  end

  assign peak_valid     = peak_valid_q;
  assign peak_amplitude = peak_amp_q;
  assign peak_time      = peak_time_q;
  assign pile_up        = pile_up_q;
  assign busy           = (state_q != StIdle);
  assign event_count    = event_q;
  assign reject_count   = reject_q;

endmodule

// File: tb/tb_peak_detector.sv
// Scoreboard bench for peak_detector: directed pulses push expected peaks, a monitor pops and
// compares on every peak_valid strobe.
module tb_peak_detector;

  localparam int DW = 16;
  localparam int TW = 32;
  localparam int MW = 8;
  localparam int CW = 3;  // small so saturation at 7 is reachable

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic signed [DW-1:0] input_data = '0;
  logic signed [DW-1:0] threshold = 16'sd100;
  logic [7:0]           dead_time = 8'd4;
  logic                 peak_valid;
  logic signed [DW-1:0] peak_amplitude;
  logic [TW-1:0]        peak_time;
  logic                 pile_up;
  logic                 busy;
  logic [CW-1:0]        event_count;
  logic [CW-1:0]        reject_count;

  peak_detector #(
    .DATA_WIDTH(DW),
    .TIME_WIDTH(TW),
    .MAX_WIDTH (MW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .input_data    (input_data),
    .threshold     (threshold),
    .dead_time     (dead_time),
    .peak_valid    (peak_valid),
    .peak_amplitude(peak_amplitude),
    .peak_time     (peak_time),
    .pile_up       (pile_up),
    .busy          (busy),
    .event_count   (event_count),
    .reject_count  (reject_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int amp;
    int tstamp;
    bit pile;
    int evc;
    int due;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   n_events = 0;
  int   edge_cnt = 0;
  int   base = 0;
  int   vec[32];

  localparam int P1[9] = '{0, 50, 150, 300, 420, 380, 200, 90, 0};
  localparam int P2[6] = '{0, 200, 500, 500, 500, 0};
  localparam int P4[8] = '{0, 200, 0, 0, 0, 0, 200, 0};
  localparam int P5[7] = '{0, 200, 0, 0, 0, 200, 0};
  localparam int P6[5] = '{-200, -40, -10, -30, -60};

  // Posedges since reset release; equals the ts of the sample driven at the following negedge.
  always @(posedge clk or posedge reset) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_peak(input int amp, input int max_idx, input int end_idx, input bit pile);
    exp_t e;
    n_events++;
    e.amp    = amp;
    e.tstamp = base + max_idx;
    e.pile   = pile;
    e.evc    = (n_events > 7) ? 7 : n_events;
    e.due    = base + end_idx + 3;
    sb.push_back(e);
  endtask

  // Drives vec[0] immediately (caller is at a negedge), then one sample per negedge.
  task automatic play(input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      input_data = DW'(vec[i]);
    end
  endtask

  task automatic idle(input int n, input int v);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      input_data = DW'(v);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_peak_valid"}, peak_valid, 0);
    check({tag, "_amplitude"}, peak_amplitude, 0);
    check({tag, "_time"}, peak_time, 0);
    check({tag, "_pile_up"}, pile_up, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_event_count"}, event_count, 0);
    check({tag, "_reject_count"}, reject_count, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && peak_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: peak_valid=1 at cycle %0d, expected 0", edge_cnt);
      end else begin
        e = sb.pop_front();
        check("strobe_cycle", edge_cnt, e.due);
        check("amplitude", peak_amplitude, e.amp);
        check("peak_time", peak_time, e.tstamp);
        check("pile_up", pile_up, e.pile);
        check("event_count", event_count, e.evc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    idle(4, 0);

    // Single pulse: peak 420 at index 4, ends on 90 at index 7.
    for (int i = 0; i < 9; i++) vec[i] = P1[i];
    @(negedge clk);
    base = edge_cnt;
    expect_peak(420, 4, 7, 1'b0);
    play(9);
    idle(14, 0);
    check("single_event_count", event_count, 1);
    check("single_amp_holds", peak_amplitude, 420);
    check("single_busy_low", busy, 0);

    // Plateau: earliest of equal maxima wins.
    for (int i = 0; i < 6; i++) vec[i] = P2[i];
    @(negedge clk);
    base = edge_cnt;
    expect_peak(500, 2, 5, 1'b0);
    play(6);
    idle(14, 0);

    // Pile-up: 20 samples of 1000, two forced exits after MW cycles each.
    dead_time = 8'd2;
    vec[0] = 0;
    for (int i = 1; i <= 20; i++) vec[i] = 1000;
    vec[21] = 0;
    @(negedge clk);
    base = edge_cnt;
    expect_peak(1000, 1, 9, 1'b1);
    expect_peak(1000, 12, 20, 1'b1);
    play(22);
    idle(14, 0);

    // Dead time 10: second pulse falls into hold-off and is rejected.
    dead_time = 8'd10;
    for (int i = 0; i < 8; i++) vec[i] = P4[i];
    @(negedge clk);
    base = edge_cnt;
    expect_peak(200, 1, 2, 1'b0);
    play(8);
    idle(16, 0);
    check("deadtime_reject_count", reject_count, 1);

    // Dead time 0: both pulses reported.
    dead_time = 8'd0;
    for (int i = 0; i < 7; i++) vec[i] = P5[i];
    @(negedge clk);
    base = edge_cnt;
    expect_peak(200, 1, 2, 1'b0);
    expect_peak(200, 5, 6, 1'b0);
    play(7);
    idle(8, 0);

    // Negative data, signed threshold; eighth event saturates the 3-bit counter.
    dead_time = 8'd4;
    idle(1, -200);
    idle(1, -200);
    threshold = -16'sd50;
    idle(3, -200);
    for (int i = 0; i < 5; i++) vec[i] = P6[i];
    @(negedge clk);
    base = edge_cnt;
    expect_peak(-10, 2, 4, 1'b0);
    play(5);
    idle(8, -200);
    check("saturated_event_count", event_count, 7);
    check("reject_count_kept", reject_count, 1);

    // Reset while armed on the 300 sample: no strobe, everything cleared.
    threshold = 16'sd100;
    idle(3, 0);
    for (int i = 0; i < 9; i++) vec[i] = P1[i];
    @(negedge clk);
    play(4);
    @(posedge clk);
    #2 check("armed_busy", busy, 1);
    reset = 1'b1;
    n_events = 0;
    #1 check_all_zero("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    base = 0;  // ts restarts at 0 on the first edge after release
    expect_peak(420, 4, 7, 1'b0);
    play(9);
    idle(14, 0);
    check("post_reset_event_count", event_count, 1);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
